// File: rtl/aes_128_inv_cipher_if.sv
// Request/response bundle for the AES-128 inverse cipher: ciphertext and key in,
// plaintext out with a completion pulse and an in-flight flag.
interface aes_128_inv_cipher_if;
  logic         i_start;
  logic [127:0] i_state;
  logic [127:0] i_key;
  logic [127:0] o_out;
  logic         o_valid;
  logic         o_busy;

  modport master (output i_start, i_state, i_key, input o_out, o_valid, o_busy);
  modport slave  (input i_start, i_state, i_key, output o_out, o_valid, o_busy);
endinterface

// File: rtl/aes_128_inv_cipher.sv
// Iterative AES-128 decryptor: runs the forward key schedule up to round key 10,
// then walks it backwards while applying one inverse round per clock.
module aes_128_inv_cipher (
  input  logic                 clk,
  input  logic                 rst,
  aes_128_inv_cipher_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, EXPAND, ROUND} fsm_t;

  fsm_t         r_fsm, w_fsm_next;
  logic [127:0] r_s, r_rk, r_out;
  logic [7:0]   r_rcon;
  logic [3:0]   r_cnt;
  logic         r_valid;

  logic [31:0]  w_sb_in, w_sub, w_k0, w_k1, w_k2, w_k3;
  logic [127:0] w_fwd, w_inv, w_isb, w_add, w_mix;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] inv_xtime(input logic [7:0] a);
    return a[0] ? (((a ^ 8'h1b) >> 1) | 8'h80) : (a >> 1);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // x^254 as the product x^2 * x^4 * ... * x^128; zero maps to zero for free.
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] r, p;
    r = 8'h01;
    p = a;
    for (int i = 0; i < 7; i++) begin
      p = gmul(p, p);
      r = gmul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b;
    b = ginv(a);
    return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] a);
    return ginv(rotl8(a, 1) ^ rotl8(a, 3) ^ rotl8(a, 6) ^ 8'h05);
  endfunction

  function automatic logic [127:0] inv_mix(input logic [127:0] x);
    logic [127:0] y;
    logic [7:0]   a0, a1, a2, a3;
    y = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = x[127-32*c -: 8];
      a1 = x[119-32*c -: 8];
      a2 = x[111-32*c -: 8];
      a3 = x[103-32*c -: 8];
      y[127-32*c -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
      y[119-32*c -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
      y[111-32*c -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
      y[103-32*c -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
    end
    return y;
  endfunction

  // One set of four S-boxes serves both directions: forward step feeds w3, backward step w3^w2.
  assign w_sb_in = (r_fsm == ROUND) ? (r_rk[31:0] ^ r_rk[63:32]) : r_rk[31:0];
  assign w_sub   = {sbox(w_sb_in[23:16]), sbox(w_sb_in[15:8]), sbox(w_sb_in[7:0]), sbox(w_sb_in[31:24])};
  assign w_k0    = r_rk[127:96] ^ w_sub ^ {r_rcon, 24'h0};
  assign w_k1    = r_rk[95:64] ^ w_k0;
  assign w_k2    = r_rk[63:32] ^ w_k1;
  assign w_k3    = r_rk[31:0]  ^ w_k2;
  assign w_fwd   = {w_k0, w_k1, w_k2, w_k3};
  assign w_inv   = {w_k0, r_rk[127:96] ^ r_rk[95:64], r_rk[95:64] ^ r_rk[63:32], r_rk[63:32] ^ r_rk[31:0]};

  // InvShiftRows folded into the byte selection feeding InvSubBytes.
  always_comb begin
    w_isb = '0;
    for (int i = 0; i < 16; i++)
      w_isb[127-8*i -: 8] = inv_sbox(r_s[127-8*((i % 4) + 4*(((i / 4) - (i % 4)) & 3)) -: 8]);
  end

  assign w_add = w_isb ^ w_inv;
  assign w_mix = inv_mix(w_add);

  always_ff @(posedge clk) begin
    if (rst) r_fsm <= IDLE;
    else     r_fsm <= w_fsm_next;
  end

  always_comb begin
    w_fsm_next = r_fsm;
    case (r_fsm)
      IDLE:    if (bus.i_start)     w_fsm_next = EXPAND;
      EXPAND:  if (r_cnt == 4'd9)   w_fsm_next = ROUND;
      ROUND:   if (r_cnt == 4'd9)   w_fsm_next = IDLE;
      default:                      w_fsm_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s     <= '0;
      r_rk    <= '0;
      r_rcon  <= '0;
      r_cnt   <= '0;
      r_out   <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_fsm)
        IDLE: if (bus.i_start) begin
          r_s    <= bus.i_state;
          r_rk   <= bus.i_key;
          r_rcon <= 8'h01;
          r_cnt  <= '0;
        end
        EXPAND: begin
          r_rk <= w_fwd;
          if (r_cnt == 4'd9) begin
            r_s   <= r_s ^ w_fwd;
            r_cnt <= '0;
          end else begin
            r_rcon <= xtime(r_rcon);
            r_cnt  <= r_cnt + 4'd1;
          end
        end
        ROUND: begin
          r_rk   <= w_inv;
          r_rcon <= inv_xtime(r_rcon);
          if (r_cnt == 4'd9) begin
            r_out   <= w_add;
            r_valid <= 1'b1;
            r_cnt   <= '0;
          end else begin
            r_s   <= w_mix;
            r_cnt <= r_cnt + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.o_out   = r_out;
  assign bus.o_valid = r_valid;
  assign bus.o_busy  = (r_fsm != IDLE);
endmodule
